// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification for alu_seq.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLTU  = 4'd2;
    localparam logic [3:0] ALU_SRL   = 4'd3;
    localparam logic [3:0] ALU_SLL   = 4'd4;
    localparam logic [3:0] ALU_OR    = 4'd5;
    localparam logic [3:0] ALU_AND   = 4'd6;
    localparam logic [3:0] ALU_XOR   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_NOR   = 4'd10;
    localparam logic [3:0] ALU_MULLO = 4'd11;
    localparam logic [3:0] ALU_MULHU = 4'd12;
    localparam logic [3:0] ALU_DIVU  = 4'd13;
    localparam logic [3:0] ALU_REMU  = 4'd14;
    localparam logic [3:0] ALU_RSVD  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op >= ALU_MULLO) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo hold the product halves, or remainder/quotient for a divide.
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic             active_q;
    logic             dz_q;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH-1:0] div_diff_s;
    logic             div_fit_s;

    // One iteration step; the divider's partial remainder never exceeds WIDTH bits.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_q, sh_q[WIDTH-1]};
        div_fit_s   = (div_shift_s >= {1'b0, b_q});
        div_diff_s  = div_shift_s[WIDTH-1:0] - b_q;
        if (div_q) begin
            acc_d = div_fit_s ? div_diff_s : div_shift_s[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], div_fit_s};
        end else begin
            acc_d = mul_sum_s[WIDTH:1];
            sh_d  = {mul_sum_s[0], sh_q[WIDTH-1:1]};
        end
    end

    // Load on start, then iterate until the down-counter reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= {WIDTH{1'b0}};
            sh_q     <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            div_q    <= 1'b0;
            active_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (start) begin
            acc_q    <= {WIDTH{1'b0}};
            sh_q     <= a;
            b_q      <= b;
            cnt_q    <= CW'(WIDTH);
            div_q    <= op_is_div;
            active_q <= 1'b1;
            dz_q     <= op_is_div && (b == {WIDTH{1'b0}});
        end else if (active_q) begin
            if (cnt_q != {CW{1'b0}}) begin
                acc_q <= acc_d;
                sh_q  <= sh_d;
                cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign done = active_q && (cnt_q == {CW{1'b0}});
    assign hi   = acc_q;
    assign lo   = sh_q;
    assign dz   = dz_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: captures operands on accept, evaluates single-cycle
// ops combinationally or hands mul/div to the iterative unit, and registers results.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] in_ext,
    input  logic             alu_src_b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             dz,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             init_q;

    logic [WIDTH-1:0] b_in_s;
    logic             accept_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic             alu_ill_s;
    logic [WIDTH-1:0] iter_res_s;

    logic             md_done_s;
    logic [WIDTH-1:0] md_hi_s;
    logic [WIDTH-1:0] md_lo_s;
    logic             md_dz_s;

    assign b_in_s   = alu_src_b ? in_ext : read_data2;
    assign in_ready = init_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept_s = in_valid && in_ready;
    assign sum_s    = {1'b0, a_q} + {1'b0, b_q};
    assign diff_s   = {1'b0, a_q} - {1'b0, b_q};
    assign shamt_s  = b_q[SHW-1:0];

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept_s && is_iter_op(alu_op)),
        .op_is_div (is_div_op(alu_op)),
        .a         (read_data1),
        .b         (b_in_s),
        .done      (md_done_s),
        .hi        (md_hi_s),
        .lo        (md_lo_s),
        .dz        (md_dz_s)
    );

    // Single-cycle ALU on the captured operands; carry is NOT borrow for SUB.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_ill_s = 1'b0;
        case (op_q)
            ALU_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res_s = diff_s[WIDTH-1:0];
                alu_c_s   = ~diff_s[WIDTH];
                alu_v_s   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            ALU_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            ALU_SRL:  alu_res_s = a_q >> shamt_s;
            ALU_SLL:  alu_res_s = a_q << shamt_s;
            ALU_SRA:  alu_res_s = $signed(a_q) >>> shamt_s;
            ALU_OR:   alu_res_s = a_q | b_q;
            ALU_AND:  alu_res_s = a_q & b_q;
            ALU_XOR:  alu_res_s = a_q ^ b_q;
            ALU_NOR:  alu_res_s = ~(a_q | b_q);
            ALU_RSVD: alu_ill_s = 1'b1;
            default:  alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // High half for MULHU/REMU (product high / remainder), low half otherwise.
    always_comb begin
        if ((op_q == ALU_MULHU) || (op_q == ALU_REMU)) begin
            iter_res_s = md_hi_s;
        end else begin
            iter_res_s = md_lo_s;
        end
    end

    // Control FSM with operand capture and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            op_q      <= ALU_ADD;
            init_q    <= 1'b0;
            out_valid <= 1'b0;
            result    <= {WIDTH{1'b0}};
            zero      <= 1'b0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                IDLE, DONE: begin
                    if ((state_q == DONE) && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (accept_s) begin
                        a_q     <= read_data1;
                        b_q     <= b_in_s;
                        op_q    <= alu_op;
                        state_q <= is_iter_op(alu_op) ? BUSY : EXEC;
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    state_q   <= DONE;
                    out_valid <= 1'b1;
                    result    <= alu_res_s;
                    zero      <= (alu_res_s == {WIDTH{1'b0}});
                    neg       <= alu_res_s[WIDTH-1];
                    carry     <= alu_c_s;
                    ovf       <= alu_v_s;
                    dz        <= 1'b0;
                    illegal   <= alu_ill_s;
                end
                BUSY: begin
                    if (md_done_s) begin
                        state_q   <= DONE;
                        out_valid <= 1'b1;
                        result    <= iter_res_s;
                        zero      <= (iter_res_s == {WIDTH{1'b0}});
                        neg       <= iter_res_s[WIDTH-1];
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        dz        <= md_dz_s;
                        illegal   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver queues hand-computed expectations on accept,
// monitor pops and compares result, flags and latency whenever a result is taken.
module tb_alu_seq;
    import alu_pkg::*;

    localparam logic [5:0] F_Z  = 6'b100000;
    localparam logic [5:0] F_N  = 6'b010000;
    localparam logic [5:0] F_C  = 6'b001000;
    localparam logic [5:0] F_O  = 6'b000100;
    localparam logic [5:0] F_DZ = 6'b000010;
    localparam logic [5:0] F_IL = 6'b000001;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [5:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] read_data1 = 32'h0;
    logic [31:0] read_data2 = 32'h0;
    logic [31:0] in_ext = 32'h0;
    logic        alu_src_b = 1'b0;
    logic [3:0]  alu_op = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, neg, carry, ovf, dz, illegal;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    bit   seen = 1'b0;

    alu_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .in_ext     (in_ext),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .neg        (neg),
        .carry      (carry),
        .ovf        (ovf),
        .dz         (dz),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] dut_flags();
        return {zero, neg, carry, ovf, dz, illegal};
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare whenever a result is handed over.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (out_valid && !seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
                end else begin
                    mon_e = sb.pop_front();
                    check32({mon_e.name, "_result"}, result, mon_e.res);
                    check32({mon_e.name, "_flags"}, {26'h0, dut_flags()}, {26'h0, mon_e.flags});
                    if (mon_e.lat > 0) begin
                        check32({mon_e.name, "_latency"}, first_cyc - mon_e.acc, mon_e.lat);
                    end
                end
                seen = 1'b0;
            end
        end
    end

    task automatic send(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ext, input logic src,
                        input logic [31:0] er, input logic [5:0] ef, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid   = 1'b1;
        alu_op     = op;
        read_data1 = a;
        read_data2 = b;
        in_ext     = ext;
        alu_src_b  = src;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready stuck at 0 for %0d cycles, required 1", nm, n);
            in_valid = 1'b0;
        end else begin
            e.name  = nm;
            e.res   = er;
            e.flags = ef;
            e.lat   = lat;
            e.acc   = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid   = 1'b0;
            read_data1 = $urandom;
            read_data2 = $urandom;
            in_ext     = $urandom;
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", nm, sb.size());
        end
    endtask

    initial begin
        int n;
        int acc_c;

        #1 rst_n = 1'b0;
        #1;
        check32("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check32("reset_result", result, 32'h0);
        check32("reset_flags", {26'h0, dut_flags()}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check32("reset_in_ready", {31'h0, in_ready}, 32'h1);

        send("add_wrap",  ALU_ADD,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h0, F_Z | F_C, 1);
        send("add_ovf",   ALU_ADD,  32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 32'h80000000, F_N | F_O, 1);
        send("sub_ovf",   ALU_SUB,  32'h80000000, 32'h1, 32'h0, 1'b0, 32'h7FFFFFFF, F_C | F_O, 1);
        send("sub_borrow",ALU_SUB,  32'h3, 32'h5, 32'h0, 1'b0, 32'hFFFFFFFE, F_N, 1);
        send("slt",       ALU_SLT,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h1, 6'b000000, 1);
        send("sltu",      ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h0, F_Z, 1);
        send("sra_ext",   ALU_SRA,  32'h80000000, 32'h1, 32'h24, 1'b1, 32'hF8000000, F_N, 1);
        send("srl",       ALU_SRL,  32'h80000000, 32'h21, 32'h0, 1'b0, 32'h40000000, 6'b000000, 1);
        send("sll",       ALU_SLL,  32'h1, 32'hFF, 32'h0, 1'b0, 32'h80000000, F_N, 1);
        send("or",        ALU_OR,   32'hF0F00000, 32'h0000FFFF, 32'h0, 1'b0, 32'hF0F0FFFF, F_N, 1);
        send("and",       ALU_AND,  32'hF0F0FFFF, 32'h0F0F00FF, 32'h0, 1'b0, 32'h000000FF, 6'b000000, 1);
        send("nor",       ALU_NOR,  32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, F_N, 1);
        send("rsvd",      ALU_RSVD, 32'h1234, 32'h5678, 32'h0, 1'b0, 32'h0, F_Z | F_IL, 1);
        send("mulhu",     ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 32'hFFFFFFFE, F_N, 33);
        send("mullo",     ALU_MULLO, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h1, 6'b000000, 33);
        send("mullo_ext", ALU_MULLO, 32'h12345678, 32'h3, 32'h10, 1'b1, 32'h23456780, 6'b000000, 33);
        send("divu",      ALU_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 32'd14, 6'b000000, 33);
        send("remu",      ALU_REMU, 32'd100, 32'd7, 32'h0, 1'b0, 32'd2, 6'b000000, 33);
        send("divu_dz",   ALU_DIVU, 32'd5, 32'd0, 32'h0, 1'b0, 32'hFFFFFFFF, F_N | F_DZ, 33);
        send("remu_dz",   ALU_REMU, 32'd5, 32'd0, 32'h0, 1'b0, 32'd5, F_DZ, 33);
        drain("main");

        // Backpressure: result must hold and no new op may be accepted.
        @(negedge clk);
        out_ready = 1'b0;
        send("xor_bp", ALU_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 1'b0, 32'hF0F00F0F, F_N, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check32("bp_out_valid", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("bp_result_hold", result, 32'hF0F00F0F);
            check32("bp_in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        drain("bp");

        // Reset in the middle of a divide.
        send("divu_aborted", ALU_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 32'd14, 6'b000000, 33);
        acc_c = cyc;
        n = 0;
        while (cyc < acc_c + 10 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        check32("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check32("midrst_result", result, 32'h0);
        check32("midrst_flags", {26'h0, dut_flags()}, 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check32("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        send("divu_after_rst", ALU_DIVU, 32'd1000, 32'd10, 32'h0, 1'b0, 32'd100, 6'b000000, 33);
        send("add_after_rst",  ALU_ADD,  32'd2, 32'd3, 32'h0, 1'b0, 32'd5, 6'b000000, 1);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
